aes_host_ctrl: RTL and testbench

AES_HOST_CTRL -- requirements
Module: aes_host_ctrl

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_byte_ser.sv | 37 +++
 rtl/aes_host_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_host_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared key-size encodings, FSM states and key length helper
package aes_pkg;

   localparam logic [1:0] AES_128 = 2'd0;
   localparam logic [1:0] AES_192 = 2'd1;
   localparam logic [1:0] AES_256 = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY,
      ST_DATA,
      ST_LOAD,
      ST_WAIT,
      ST_OUT
   } state_e;

   // Reserved size 3 is treated like AES-256.
   function automatic logic [5:0] key_bytes(input logic [1:0] size);
      case (size)
         AES_128: return 6'd16;
         AES_192: return 6'd24;
         AES_256: return 6'd32;
         default: return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/aes_byte_ser.sv
// rtl/aes_byte_ser.sv - holds a 128-bit result and streams it MSB byte first
module aes_byte_ser (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [127:0] data_i,
   output logic         out_valid_o,
   output logic [7:0]   out_data_o,
   output logic         out_last_o,
   input  logic         out_ready_i
);

   logic [127:0] shift_q;
   logic [3:0]   cnt_q;
   logic         valid_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         shift_q <= data_i;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && out_ready_i) begin
         shift_q <= {shift_q[119:0], 8'h00};
         cnt_q   <= cnt_q + 4'd1;
         if (cnt_q == 4'd15) valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = shift_q[127:120];
   assign out_last_o  = valid_q && (cnt_q == 4'd15);

endmodule

// File: rtl/aes_host_ctrl.sv
// rtl/aes_host_ctrl.sv - byte-stream host front end for an AES core
// Optional WAIT timeout with sticky err_o enabled by AES_HOST_TIMEOUT_EN.
module aes_host_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid_i,
   input  logic [7:0]   in_data_i,
   output logic         in_ready_o,
   output logic         out_valid_o,
   output logic [7:0]   out_data_o,
   output logic         out_last_o,
   input  logic         out_ready_i,
   output logic         load_o,
   output logic [255:0] key_o,
   output logic [127:0] data_o,
   output logic [1:0]   size_o,
   output logic         dec_o,
   input  logic [127:0] data_i,
   input  logic         busy_i,
   output logic         active_o,
   output logic         err_o
);
   import aes_pkg::*;

   state_e         state_q, state_d;
   logic [4:0]     cnt_q;
   logic [255:0]   key_q;
   logic [127:0]   data_q;
   logic [1:0]     size_q;
   logic           dec_q, load_q, active_q, in_ready_q, err_q, wait_seen_q;
   logic           in_acc, key_done, data_done, capture, out_done, timeout;

   assign in_acc    = in_valid_i && in_ready_q;
   assign key_done  = ({1'b0, cnt_q} == key_bytes(size_q) - 6'd1);
   assign data_done = (cnt_q == 5'd15);
   // The core may not have raised busy yet in the first WAIT cycle.
   assign capture   = (state_q == ST_WAIT) && wait_seen_q && !busy_i;
   assign out_done  = out_valid_o && out_ready_i && out_last_o;

`ifdef AES_HOST_TIMEOUT_EN
   localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WCW-1:0] wcnt_q;

   assign timeout = (state_q == ST_WAIT) && busy_i && (wcnt_q == WCW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || state_q != ST_WAIT) wcnt_q <= '0;
      else                                wcnt_q <= wcnt_q + 1'b1;
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_acc) state_d = ST_KEY;
         ST_KEY:  if (in_acc && key_done) state_d = ST_DATA;
         ST_DATA: if (in_acc && data_done) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (timeout)      state_d = ST_IDLE;
            else if (capture) state_d = ST_OUT;
         end
         ST_OUT:  if (out_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         data_q      <= '0;
         size_q      <= '0;
         dec_q       <= 1'b0;
         load_q      <= 1'b0;
         active_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         err_q       <= 1'b0;
         wait_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= state_d inside {ST_IDLE, ST_KEY, ST_DATA};
         active_q    <= (state_d != ST_IDLE);
         load_q      <= (state_d == ST_LOAD);
         wait_seen_q <= (state_q == ST_WAIT) && (state_d == ST_WAIT);
         if (state_d != state_q) cnt_q <= '0;
         else if (in_acc)        cnt_q <= cnt_q + 5'd1;
         if (timeout) err_q <= 1'b1;
         if (in_acc) begin
            case (state_q)
               ST_IDLE: begin
                  size_q <= in_data_i[1:0];
                  dec_q  <= in_data_i[2];
                  key_q  <= '0;
                  data_q <= '0;
                  err_q  <= 1'b0;
               end
               // Byte n lands at bit 255-8n, i.e. index {~n, 3'b111}.
               ST_KEY:  key_q[{~cnt_q, 3'b111} -: 8] <= in_data_i;
               ST_DATA: data_q[{~cnt_q[3:0], 3'b111} -: 8] <= in_data_i;
               default: ;
            endcase
         end
      end
   end

   aes_byte_ser u_ser (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (capture),
      .data_i      (data_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready_i)
   );

   assign in_ready_o = in_ready_q;
   assign load_o     = load_q;
   assign key_o      = key_q;
   assign data_o     = data_q;
   assign size_o     = size_q;
   assign dec_o      = dec_q;
   assign active_o   = active_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// tb/tb_aes_host_ctrl.sv - randomized bench with a transaction-level model of the host controller
module tb_aes_host_ctrl;

`ifdef AES_HOST_TIMEOUT_EN
   localparam int TO    = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 1024;
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [127:0] FIXED_RES = 128'h1c060f4c9e7ea8d6ca961a2d64c05c18;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid_i;
   logic [7:0]   in_data_i;
   logic         in_ready_o;
   logic         out_valid_o;
   logic [7:0]   out_data_o;
   logic         out_last_o;
   logic         out_ready_i;
   logic         load_o;
   logic [255:0] key_o;
   logic [127:0] data_o;
   logic [1:0]   size_o;
   logic         dec_o;
   logic [127:0] data_i;
   logic         busy_i;
   logic         active_o;
   logic         err_o;

   always #5 clk = ~clk;

   aes_host_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
      .out_ready_i(out_ready_i), .load_o(load_o), .key_o(key_o), .data_o(data_o),
      .size_o(size_o), .dec_o(dec_o), .data_i(data_i), .busy_i(busy_i),
      .active_o(active_o), .err_o(err_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: command bytes seen, pending result bytes, expected handshake status.
   int           acc_n = 0, cmd_len = 0, kb = 16, wait_k = 0, out_idx = 0, seen_len = 0, last_at = 0;
   logic         exp_ready = 1'b1, exp_err = 1'b0, load_due = 1'b0, held_valid = 1'b0;
   logic         prev_stall = 1'b0;
   logic [255:0] kacc, held_key;
   logic [127:0] dacc, held_data;
   logic [1:0]   msize, held_size;
   logic         mdec, held_dec;
   logic [7:0]   prev_data;
   logic [7:0]   exp_q[$];
   logic [7:0]   out_log[$];

   always @(negedge clk) begin
      if (!reset_n) begin
         acc_n = 0; exp_ready = 1'b1; exp_err = 1'b0; load_due = 1'b0; held_valid = 1'b0;
         wait_k = 0; out_idx = 0; prev_stall = 1'b0; exp_q.delete();
      end else begin
         chk("in_ready", in_ready_o, exp_ready);
         chk("active", active_o, !(exp_ready && acc_n == 0));
         chk("err", err_o, exp_err);
         chk("load", load_o, load_due);
         chk("out_valid", out_valid_o, exp_q.size() != 0);
         if (out_valid_o && exp_q.size() != 0) begin
            chk("out_data", out_data_o, exp_q[0]);
            chk("out_last", out_last_o, out_idx == 15);
         end
         if (prev_stall) chk("out_hold", out_data_o, prev_data);
         if (load_due) begin
            held_valid = 1'b1;
            held_key   = kacc << (8 * (32 - kb));
            held_data  = dacc;
            held_size  = msize;
            held_dec   = mdec;
            seen_len   = cmd_len;
         end
         if (held_valid) begin
            chk("key_o", key_o, held_key);
            chk("data_o", data_o, held_data);
            chk("size_o", size_o, held_size);
            chk("dec_o", dec_o, held_dec);
         end
         if (wait_k > 0) begin
            if (wait_k >= 2 && !busy_i) begin
               for (int i = 0; i < 16; i++) exp_q.push_back(8'(data_i >> (8 * (15 - i))));
               wait_k = 0;
            end else if (TO_EN && wait_k == TO && busy_i) begin
               exp_err = 1'b1; exp_ready = 1'b1; acc_n = 0; wait_k = 0;
            end else begin
               wait_k++;
            end
         end
         if (load_due) wait_k = 1;
         load_due = 1'b0;
         if (in_valid_i && in_ready_o) begin
            if (acc_n == 0) begin
               msize = in_data_i[1:0];
               mdec  = in_data_i[2];
               kb    = (msize == 2'd0) ? 16 : (msize == 2'd1) ? 24 : 32;
               cmd_len = 17 + kb;
               kacc = '0; dacc = '0; exp_err = 1'b0; held_valid = 1'b0;
            end else if (acc_n <= kb) begin
               kacc = {kacc[247:0], in_data_i};
            end else begin
               dacc = {dacc[119:0], in_data_i};
            end
            acc_n++;
            if (acc_n == cmd_len) begin
               exp_ready = 1'b0;
               load_due  = 1'b1;
            end
         end
         if (out_valid_o && out_ready_i) begin
            out_log.push_back(out_data_o);
            if (out_last_o) last_at = out_log.size();
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               out_idx++;
               if (out_idx == 16) begin
                  out_idx = 0; exp_ready = 1'b1; acc_n = 0;
               end
            end
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_data  = out_data_o;
      end
   end

   // AES core stand-in: busy for core_lat cycles after load, then presents the result.
   int           core_lat = 1;
   bit           core_fixed = 1'b0;
   int           lat_c;
   logic [127:0] res_c;

   initial begin
      busy_i = 1'b0;
      data_i = '0;
      forever begin
         @(negedge clk);
         if (reset_n && load_o) begin
            lat_c = core_lat;
            res_c = core_fixed ? FIXED_RES : {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            if (lat_c == 0) begin
               data_i = res_c;
            end else begin
               busy_i = 1'b1;
               data_i = {$urandom, $urandom, $urandom, $urandom};
               repeat (lat_c) begin @(posedge clk); #1; end
               busy_i = 1'b0;
               data_i = res_c;
            end
         end
      end
   end

   int sink_mode = 0;
   initial begin
      out_ready_i = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (sink_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = ~out_ready_i;
         endcase
      end
   end

   int gap_max = 0;

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      in_valid_i = 1'b1;
      in_data_i  = b;
      do begin @(negedge clk); n++; end while (!in_ready_o && n < 2000);
      checks++;
      if (!in_ready_o) begin
         failures++;
         $display("FAIL send_byte: in_ready_o got 0 expected 1 for byte %h", b);
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] hdr, input logic [255:0] key, input logic [127:0] dat);
      int nk;
      nk = (hdr[1:0] == 2'd0) ? 16 : (hdr[1:0] == 2'd1) ? 24 : 32;
      send_byte(hdr);
      for (int i = 0; i < nk; i++) send_byte(8'(key >> (8 * (31 - i))));
      for (int i = 0; i < 16; i++) send_byte(8'(dat >> (8 * (15 - i))));
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (active_o && n < bound);
      chk("wait_idle", active_o, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic count_until_load(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!load_o && n < 100);
      chk("load_seen", load_o, 1'b1);
   endtask

   int n;

   initial begin
      reset_n    = 1'b0;
      in_valid_i = 1'b0;
      in_data_i  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready_o, 1'b1);
      chk("rst_active", active_o, 1'b0);
      chk("rst_load", load_o, 1'b0);
      chk("rst_out_valid", out_valid_o, 1'b0);
      chk("rst_out_last", out_last_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_key", key_o, '0);
      chk("rst_data", data_o, '0);
      chk("rst_size_dec", {size_o, dec_o}, 3'b000);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Known-answer command with a one-cycle core.
      core_fixed = 1'b1; core_lat = 1; sink_mode = 0; out_log.delete();
      send_cmd(8'h00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff);
      count_until_load(n);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid_o && n < 50);
      chk("kat_latency", n, 3);
      wait_idle(200);
      chk("kat_key_o", key_o, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      chk("kat_data_o", data_o, 128'h00112233445566778899aabbccddeeff);
      chk("kat_nbytes", out_log.size(), 16);
      if (out_log.size() == 16) begin
         chk("kat_first", out_log[0], 8'h1c);
         chk("kat_second", out_log[1], 8'h06);
         chk("kat_final", out_log[15], 8'h18);
      end
      chk("kat_last_pos", last_at, 16);
      core_fixed = 1'b0;

      // Output back-pressure with out_ready toggling.
      sink_mode = 2; out_log.delete();
      send_cmd(8'h01, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
      wait_idle(300);
      chk("toggle_nbytes", out_log.size(), 16);

      // AES-256 decrypt header, 1+32+16 bytes before in_ready drops.
      sink_mode = 0;
      send_cmd(8'h06, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
      wait_idle(300);
      chk("a256_len", seen_len, 49);
      chk("a256_size", size_o, 2'd2);
      chk("a256_dec", dec_o, 1'b1);

      // Randomized traffic, including reserved size 3 and junk header bits.
      sink_mode = 1; gap_max = 2;
      for (int k = 0; k < 20; k++) begin
         core_lat = $urandom_range(0, 4);
         send_cmd(8'($urandom),
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
      end
      wait_idle(500);

      // Reset while the core is still busy: nothing must come out afterwards.
      sink_mode = 0; gap_max = 0; core_lat = 6; out_log.delete();
      send_cmd(8'h00, {$urandom, $urandom, $urandom, $urandom, 128'h0}, {$urandom, $urandom, $urandom, $urandom});
      count_until_load(n);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rstwait_active", active_o, 1'b0);
      chk("rstwait_nbytes", out_log.size(), 0);
      @(posedge clk); #1;
      core_lat = 0;
      send_cmd(8'h01, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0},
               {$urandom, $urandom, $urandom, $urandom});
      wait_idle(300);
      chk("rstwait_after_nbytes", out_log.size(), 16);

`ifdef AES_HOST_TIMEOUT_EN
      // Core stuck busy: timeout after TO WAIT cycles, cleared by the next header.
      core_lat = 20;
      send_cmd(8'h02, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
      count_until_load(n);
      n = 0;
      do begin @(negedge clk); n++; end while (!err_o && n < 100);
      chk("to_cycles", n, 9);
      chk("to_err", err_o, 1'b1);
      chk("to_idle", {active_o, in_ready_o}, 2'b01);
      repeat (25) begin @(posedge clk); #1; end
      core_lat = 1;
      send_cmd(8'h00, {$urandom, $urandom, $urandom, $urandom, 128'h0}, {$urandom, $urandom, $urandom, $urandom});
      wait_idle(300);
      chk("to_err_clear", err_o, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
